// File: rtl/decode_ctrl_pkg.sv
// Shared decode definitions: RV32I opcodes, immediate-format codes and the
// ID/EX control bundle. The IMM_* codes are also what imm_gen consumes, so
// they must not be renumbered.
package decode_ctrl_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  // addi x0,x0,0 -- what the ID/EX register shows when it holds nothing
  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;

  typedef enum logic {
    ST_RUN,
    ST_DRAIN
  } state_e;

  typedef struct packed {
    logic [2:0] imm_sel;
    logic       reg_we;
    logic       mem_re;
    logic       mem_we;
    logic       br;
    logic       jmp;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/decode_ctrl_decode_logic.sv
// Purely combinational opcode decoder: immediate format, datapath control
// flags and which source registers the instruction actually reads.
module decode_logic
  import decode_ctrl_pkg::*;
(
  input  logic [6:0] opcode_i,
  output logic [2:0] imm_sel_o,
  output logic       reg_we_o,
  output logic       mem_re_o,
  output logic       mem_we_o,
  output logic       br_o,
  output logic       jmp_o,
  output logic       illegal_o,
  output logic       uses_rs1_o,
  output logic       uses_rs2_o
);

  // Opcode lookup; anything unrecognised is flagged illegal with no side effects
  always_comb begin
    imm_sel_o  = IMM_I;
    reg_we_o   = 1'b0;
    mem_re_o   = 1'b0;
    mem_we_o   = 1'b0;
    br_o       = 1'b0;
    jmp_o      = 1'b0;
    illegal_o  = 1'b0;
    uses_rs1_o = 1'b1;
    uses_rs2_o = 1'b0;
    case (opcode_i)
      OPC_LUI, OPC_AUIPC: begin
        imm_sel_o  = IMM_U;
        reg_we_o   = 1'b1;
        uses_rs1_o = 1'b0;
      end
      OPC_JAL: begin
        imm_sel_o  = IMM_J;
        reg_we_o   = 1'b1;
        jmp_o      = 1'b1;
        uses_rs1_o = 1'b0;
      end
      OPC_JALR: begin
        reg_we_o = 1'b1;
        jmp_o    = 1'b1;
      end
      OPC_BRANCH: begin
        imm_sel_o  = IMM_B;
        br_o       = 1'b1;
        uses_rs2_o = 1'b1;
      end
      OPC_LOAD: begin
        reg_we_o = 1'b1;
        mem_re_o = 1'b1;
      end
      OPC_STORE: begin
        imm_sel_o  = IMM_S;
        mem_we_o   = 1'b1;
        uses_rs2_o = 1'b1;
      end
      OPC_OP_IMM, OPC_SYSTEM: begin
        reg_we_o = 1'b1;
      end
      OPC_OP: begin
        reg_we_o   = 1'b1;
        uses_rs2_o = 1'b1;
      end
      default: begin
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/decode_ctrl.sv
// Decode-stage controller: decodes the fetched instruction into the ID/EX
// register, inserts one bubble on a load-use hazard and discards wrong-path
// fetches for a fixed number of cycles after a redirect.
module decode_ctrl
  import decode_ctrl_pkg::*;
#(
  parameter logic [31:0] NOP_INST     = NOP_INST_DEF,
  parameter int          DRAIN_CYCLES = 1,
  parameter int          CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_valid,
  input  logic [31:0]      if_inst,
  input  logic [31:0]      if_pc,
  output logic             id_ready,
  input  logic             flush,
  input  logic             ex_ready,
  output logic             ex_valid,
  output logic [31:0]      ex_inst,
  output logic [31:0]      ex_pc,
  output logic [2:0]       ex_imm_sel,
  output logic             ex_reg_we,
  output logic             ex_mem_re,
  output logic             ex_mem_we,
  output logic             ex_br,
  output logic             ex_jmp,
  output logic             ex_illegal,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam logic [2:0] DRAIN_LD = 3'(DRAIN_CYCLES);

  state_e           state_q, state_d;
  logic [2:0]       drain_q, drain_d;
  logic             ex_valid_q, ex_valid_d;
  logic [31:0]      ex_inst_q, ex_inst_d;
  logic [31:0]      ex_pc_q, ex_pc_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic [CNT_W-1:0] bubble_q, bubble_d;
  logic [CNT_W-1:0] drop_q, drop_d;

  ctrl_t            dec_ctrl;
  logic             dec_rs1, dec_rs2;
  logic [4:0]       ld_rd;
  logic             hz;
  logic             rdy;

  decode_logic u_dec (
    .opcode_i   (if_inst[6:0]),
    .imm_sel_o  (dec_ctrl.imm_sel),
    .reg_we_o   (dec_ctrl.reg_we),
    .mem_re_o   (dec_ctrl.mem_re),
    .mem_we_o   (dec_ctrl.mem_we),
    .br_o       (dec_ctrl.br),
    .jmp_o      (dec_ctrl.jmp),
    .illegal_o  (dec_ctrl.illegal),
    .uses_rs1_o (dec_rs1),
    .uses_rs2_o (dec_rs2)
  );

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Load in EX whose rd (non-x0) feeds a source the incoming instruction reads
  assign ld_rd = ex_inst_q[11:7];
  assign hz    = ex_valid_q & ctrl_q.mem_re & (ld_rd != 5'd0) &
                 ((dec_rs1 & (if_inst[19:15] == ld_rd)) |
                  (dec_rs2 & (if_inst[24:20] == ld_rd)));

  // Next-state: flush dominates, then accept, then bubble/consume/hold
  always_comb begin
    state_d    = state_q;
    drain_d    = drain_q;
    ex_valid_d = ex_valid_q;
    ex_inst_d  = ex_inst_q;
    ex_pc_d    = ex_pc_q;
    ctrl_d     = ctrl_q;
    bubble_d   = bubble_q;
    drop_d     = drop_q;
    rdy        = 1'b0;
    case (state_q)
      ST_RUN: begin
        rdy = !flush & !hz & (!ex_valid_q | ex_ready);
        if (flush) begin
          ex_valid_d = 1'b0;
          ex_inst_d  = NOP_INST;
          ex_pc_d    = '0;
          ctrl_d     = '0;
          state_d    = ST_DRAIN;
          drain_d    = DRAIN_LD;
        end else if (if_valid & rdy) begin
          ex_valid_d = 1'b1;
          ex_inst_d  = if_inst;
          ex_pc_d    = if_pc;
          ctrl_d     = dec_ctrl;
        end else begin
          // A stalled hazard (EX not consuming) is a plain hold, not a bubble
          if (hz & ex_ready & if_valid) bubble_d = sat_inc(bubble_q);
          if (!ex_valid_q | ex_ready) begin
            ex_valid_d = 1'b0;
            ex_inst_d  = NOP_INST;
            ex_pc_d    = '0;
            ctrl_d     = '0;
          end
        end
      end
      ST_DRAIN: begin
        rdy        = !flush;
        ex_valid_d = 1'b0;
        ex_inst_d  = NOP_INST;
        ex_pc_d    = '0;
        ctrl_d     = '0;
        if (flush) begin
          drain_d = DRAIN_LD;
        end else begin
          if (if_valid) drop_d = sat_inc(drop_q);
          drain_d = drain_q - 3'd1;
          if (drain_q == 3'd1) state_d = ST_RUN;
        end
      end
    endcase
  end

  // ID/EX pipeline register, FSM and performance counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RUN;
      drain_q    <= 3'd0;
      ex_valid_q <= 1'b0;
      ex_inst_q  <= NOP_INST;
      ex_pc_q    <= '0;
      ctrl_q     <= '0;
      bubble_q   <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      drain_q    <= drain_d;
      ex_valid_q <= ex_valid_d;
      ex_inst_q  <= ex_inst_d;
      ex_pc_q    <= ex_pc_d;
      ctrl_q     <= ctrl_d;
      bubble_q   <= bubble_d;
      drop_q     <= drop_d;
    end
  end

  assign id_ready   = rdy;
  assign ex_valid   = ex_valid_q;
  assign ex_inst    = ex_inst_q;
  assign ex_pc      = ex_pc_q;
  assign ex_imm_sel = ctrl_q.imm_sel;
  assign ex_reg_we  = ctrl_q.reg_we;
  assign ex_mem_re  = ctrl_q.mem_re;
  assign ex_mem_we  = ctrl_q.mem_we;
  assign ex_br      = ctrl_q.br;
  assign ex_jmp     = ctrl_q.jmp;
  assign ex_illegal = ctrl_q.illegal;
  assign bubble_cnt = bubble_q;
  assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_decode_ctrl.sv
// Bench for decode_ctrl: directed scenarios plus randomized traffic, all
// checked every cycle against a behavioural model of the decode stage.
module tb_decode_ctrl;

  localparam int DRAIN = 2;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_valid;
  logic [31:0]   if_inst;
  logic [31:0]   if_pc;
  logic          id_ready;
  logic          flush;
  logic          ex_ready;
  logic          ex_valid;
  logic [31:0]   ex_inst;
  logic [31:0]   ex_pc;
  logic [2:0]    ex_imm_sel;
  logic          ex_reg_we, ex_mem_re, ex_mem_we, ex_br, ex_jmp, ex_illegal;
  logic [CW-1:0] bubble_cnt, drop_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  // behavioural model state
  logic        m_valid;
  logic [31:0] m_inst;
  logic [31:0] m_pc;
  logic [8:0]  m_ctl;     // {imm_sel, reg_we, mem_re, mem_we, br, jmp, illegal}
  int          m_drain;   // remaining discard cycles; 0 means running
  int          m_bub;
  int          m_drop;

  decode_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc), .id_ready(id_ready),
    .flush(flush), .ex_ready(ex_ready),
    .ex_valid(ex_valid), .ex_inst(ex_inst), .ex_pc(ex_pc), .ex_imm_sel(ex_imm_sel),
    .ex_reg_we(ex_reg_we), .ex_mem_re(ex_mem_re), .ex_mem_we(ex_mem_we),
    .ex_br(ex_br), .ex_jmp(ex_jmp), .ex_illegal(ex_illegal),
    .bubble_cnt(bubble_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] m_dec(input logic [6:0] op);
    case (op)
      7'b0110111, 7'b0010111:            return {3'd3, 6'b100000};
      7'b1101111:                        return {3'd4, 6'b100010};
      7'b1100111:                        return {3'd0, 6'b100010};
      7'b1100011:                        return {3'd2, 6'b000100};
      7'b0000011:                        return {3'd0, 6'b110000};
      7'b0100011:                        return {3'd1, 6'b001000};
      7'b0010011, 7'b0110011, 7'b1110011: return {3'd0, 6'b100000};
      default:                           return {3'd0, 6'b000001};
    endcase
  endfunction

  function automatic bit m_rs1(input logic [6:0] op);
    return !(op == 7'b0110111 || op == 7'b0010111 || op == 7'b1101111);
  endfunction

  function automatic bit m_rs2(input logic [6:0] op);
    return op == 7'b1100011 || op == 7'b0100011 || op == 7'b0110011;
  endfunction

  function automatic bit m_hz();
    logic [4:0] rd;
    rd = m_inst[11:7];
    return m_valid && m_ctl[4] && rd != 0 &&
           ((m_rs1(if_inst[6:0]) && if_inst[19:15] == rd) ||
            (m_rs2(if_inst[6:0]) && if_inst[24:20] == rd));
  endfunction

  function automatic bit m_ready();
    if (flush) return 1'b0;
    if (m_drain > 0) return 1'b1;
    return !m_hz() && (!m_valid || ex_ready);
  endfunction

  task automatic m_clear();
    m_valid = 1'b0; m_inst = 32'h13; m_pc = 0; m_ctl = 0;
  endtask

  task automatic m_reset();
    m_clear(); m_drain = 0; m_bub = 0; m_drop = 0;
  endtask

  // one clock of the decode stage, evaluated on the inputs presently driven
  task automatic m_step(input bit rdy);
    bit hz;
    hz = m_hz();
    if (m_drain > 0) begin
      m_clear();
      if (flush) m_drain = DRAIN;
      else begin
        if (if_valid && m_drop < CMAX) m_drop++;
        m_drain--;
      end
    end else if (flush) begin
      m_clear();
      m_drain = DRAIN;
    end else if (if_valid && rdy) begin
      m_valid = 1'b1; m_inst = if_inst; m_pc = if_pc; m_ctl = m_dec(if_inst[6:0]);
    end else begin
      if (hz && ex_ready && if_valid && m_bub < CMAX) m_bub++;
      if (!m_valid || ex_ready) m_clear();
    end
  endtask

  task automatic cmp_outputs();
    chk("ex_valid", 32'(ex_valid), 32'(m_valid));
    chk("ex_inst", ex_inst, m_inst);
    chk("ex_pc", ex_pc, m_pc);
    chk("ex_ctrl", 32'({ex_imm_sel, ex_reg_we, ex_mem_re, ex_mem_we, ex_br, ex_jmp, ex_illegal}),
        32'(m_ctl));
    chk("bubble_cnt", 32'(bubble_cnt), 32'(m_bub));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
  endtask

  // drive one cycle of inputs, check id_ready, clock, check registered outputs
  task automatic cycle(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                       input logic fl, input logic er);
    bit rdy;
    if_valid = v; if_inst = inst; if_pc = pc; flush = fl; ex_ready = er;
    #1;
    rdy = m_ready();
    chk("id_ready", 32'(id_ready), 32'(rdy));
    m_step(rdy);
    @(posedge clk); #1;
    cmp_outputs();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ex_valid"}, 32'(ex_valid), 32'd0);
    chk({tag, "_ex_inst"}, ex_inst, 32'h0000_0013);
    chk({tag, "_ex_pc"}, ex_pc, 32'd0);
    chk({tag, "_imm_sel"}, 32'(ex_imm_sel), 32'd0);
    chk({tag, "_bubble"}, 32'(bubble_cnt), 32'd0);
    chk({tag, "_drop"}, 32'(drop_cnt), 32'd0);
  endtask

  function automatic logic [31:0] rnd_inst();
    logic [6:0] op;
    case ($urandom_range(0, 11))
      0: op = 7'b0110111;  1: op = 7'b0010111;  2: op = 7'b1101111;
      3: op = 7'b1100111;  4: op = 7'b1100011;  5: op = 7'b0000011;
      6: op = 7'b0100011;  7: op = 7'b0010011;  8: op = 7'b0110011;
      9: op = 7'b1110011;  10: op = 7'b0000011;
      default: op = 7'($urandom);
    endcase
    return {7'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            3'($urandom), 5'($urandom_range(0, 3)), op};
  endfunction

  localparam logic [31:0] ADDI  = 32'h00A00093;
  localparam logic [31:0] LW    = 32'h0000A103;
  localparam logic [31:0] ADD   = 32'h002081B3;
  localparam logic [31:0] STORE = 32'h0020A023;

  initial begin
    logic [6:0]  ops [4];
    logic [2:0]  imms [4];
    ops  = '{7'b0110111, 7'b1101111, 7'b1100011, 7'b1111111};
    imms = '{3'd3, 3'd4, 3'd2, 3'd0};

    rst = 1'b1; if_valid = 0; if_inst = 0; if_pc = 0; flush = 0; ex_ready = 0;
    m_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_reset_vals("reset");

    // addi accepted with one-cycle latency
    cycle(1, ADDI, 32'h100, 0, 1);
    chk("addi_valid", 32'(ex_valid), 32'd1);
    chk("addi_imm", 32'(ex_imm_sel), 32'd0);
    chk("addi_we", 32'(ex_reg_we), 32'd1);
    chk("addi_pc", ex_pc, 32'h100);

    // load-use: one bubble, then the add goes through
    cycle(1, LW, 32'h104, 0, 1);
    cycle(1, ADD, 32'h108, 0, 1);
    chk("bubble_valid", 32'(ex_valid), 32'd0);
    chk("bubble_cnt1", 32'(bubble_cnt), 32'd1);
    cycle(1, ADD, 32'h108, 0, 1);
    chk("add_inst", ex_inst, ADD);

    // store held while EX stalls
    cycle(1, STORE, 32'h10C, 0, 1);
    for (int i = 0; i < 3; i++) begin
      cycle(1, ADDI, 32'h110, 0, 0);
      chk("hold_inst", ex_inst, STORE);
      chk("hold_imm", 32'(ex_imm_sel), 32'd1);
      chk("hold_rdy", 32'(id_ready), 32'd0);
    end
    chk("hold_bubble", 32'(bubble_cnt), 32'd1);

    // flush with a live instruction, then two discarded beats
    cycle(1, ADDI, 32'h110, 1, 0);
    chk("flush_valid", 32'(ex_valid), 32'd0);
    cycle(1, ADDI, 32'h200, 0, 1);
    cycle(1, ADDI, 32'h204, 0, 1);
    chk("drain_drop", 32'(drop_cnt), 32'd2);
    cycle(1, ADDI, 32'h300, 0, 1);
    chk("post_drain_valid", 32'(ex_valid), 32'd1);
    chk("post_drain_pc", ex_pc, 32'h300);

    // immediate select / illegal for selected opcodes
    for (int i = 0; i < 4; i++) begin
      cycle(1, {25'd0, ops[i]}, 32'h400 + 32'(i * 4), 0, 1);
      chk("op_imm", 32'(ex_imm_sel), 32'(imms[i]));
      chk("op_illegal", 32'(ex_illegal), (i == 3) ? 32'd1 : 32'd0);
    end

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 3) != 0, rnd_inst(), $urandom,
            $urandom_range(0, 11) == 0, $urandom_range(0, 3) != 0);
    end

    // drop counter saturates
    for (int i = 0; i < 10; i++) begin
      cycle(1, ADDI, 32'h500, 1, 1);
      cycle(1, ADDI, 32'h504, 0, 1);
      cycle(1, ADDI, 32'h508, 0, 1);
    end
    chk("drop_sat", 32'(drop_cnt), 32'(CMAX));

    // reset in the middle of a drain
    cycle(1, ADDI, 32'h600, 1, 1);
    cycle(1, ADDI, 32'h604, 0, 1);
    #2 rst = 1'b1;
    #1;
    chk_reset_vals("mid_drain_rst");
    m_reset();
    if_valid = 0; flush = 0;
    @(posedge clk); #1 rst = 1'b0;
    cycle(1, ADDI, 32'h700, 0, 1);
    chk("post_rst_valid", 32'(ex_valid), 32'd1);
    chk("post_rst_pc", ex_pc, 32'h700);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
